dg_pkt_gen: RTL
===============

# dg_pkt_gen

Packet generator for one input port of the data-generation bench, sitting directly downstream of the per-port record RAM (`dg_ram`). It walks the RAM from address 0 and decodes one 32-bit record per packet. For each record it idles for the record's wait count, then emits a header beat plus `len` payload beats on a valid/ready stream into the port under test. It stops at a terminator record or at the last RAM address.

## Interface
- `DATA_WIDTH`, 32: RAM word and stream beat width; fixed at 32 by the record format.
- `ADDR_WIDTH`, 10: RAM address width; record capacity is 2^ADDR_WIDTH.
- `ID`, 0: port index (0..15), embedded in payload.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `i_start` in 1: one-cycle pulse; starts a run. Ignored unless in IDLE or DONE.
- `o_ram_en` out 1: RAM read enable.
- `o_ram_we` out 1: constant 0.
- `o_ram_addr` out ADDR_WIDTH: record address.
- `o_ram_wdata` out DATA_WIDTH: constant 0.
- `i_ram_rdata` in DATA_WIDTH: RAM read data, valid one cycle after `o_ram_en`.
- `o_vld` out 1: stream valid.
- `i_rdy` in 1: stream ready from the sink.
- `o_sop` out 1: first beat (header) of a packet.
- `o_eop` out 1: last payload beat.
- `o_data` out DATA_WIDTH: beat data.
- `o_busy` out 1: high in every state except IDLE and DONE.
- `o_done` out 1: high in DONE.

## Operation
- Record fields:
  - `da` = [3:0]
  - `prior` = [6:4]
  - `len` = [16:7], payload beats, 1..1023
  - `wait` = [26:17], idle cycles
  - [31:27] ignored
- `len == 0` marks a terminator record.
- Header beat = {15'b0, len, prior, da}.
- Payload beat k (k = 0..len-1) = {ID[3:0], pkt_seq[11:0], k[15:0]}.
  - `pkt_seq` counts emitted packets from 0 per run and wraps at 4096.
- FSM:
  - IDLE: waits for `i_start`.
  - FETCH: `o_ram_en`=1 at the current address.
  - LATCH: captures `i_ram_rdata`. If `len`==0, go to DONE. Otherwise load the wait counter and go to WAIT.
  - WAIT: decrements the counter each cycle. When it is 0, go to HDR. A wait of 0 passes through WAIT in a single cycle.
  - HDR: drives the header with `o_sop`; advances on `o_vld & i_rdy`.
  - DATA: drives payload beats; advances on handshake. Asserts `o_eop` on the beat with k = len-1. After that handshake:
    - if the address is 2^ADDR_WIDTH-1, go to DONE;
    - else increment the address and go to FETCH.
  - DONE: holds until `i_start`, which resets address and `pkt_seq` and goes to FETCH.
- Stream rules:
  - `o_data`, `o_sop` and `o_eop` stay stable while `o_vld & !i_rdy`.
  - `o_vld` is never withdrawn before its handshake.
- `i_start` while busy is ignored.
- Reset mid-packet aborts the packet immediately. No `o_eop` is emitted for it.

## Timing
- Reset values: `o_vld`, `o_sop`, `o_eop`, `o_ram_en`, `o_busy`, `o_done` = 0; `o_data` and `o_ram_addr` = 0; state = IDLE.
- All outputs are registered.
- Start pulse to the first `o_ram_en` is 1 cycle.
- `o_ram_en` to the LATCH capture is 1 cycle.
- Header `o_vld` rises wait+1 cycles after LATCH.
- With `i_rdy` held high, a packet occupies len+1 consecutive beats.
- Inter-packet gap (EOP handshake to next SOP) is 3 + wait cycles: FETCH, LATCH and WAIT pass plus wait.
- Counter widths:
  - beat index: 10 bits, compared against `len`-1;
  - wait: 10 bits;
  - no arithmetic overflow is possible within field ranges.

## Configuration
- `DG_STAT_EN` defined: adds outputs `o_pkt_cnt` (16-bit) and `o_beat_cnt` (32-bit).
  - `o_pkt_cnt` counts EOP handshakes; `o_beat_cnt` counts all handshakes.
  - Both clear on reset and on `i_start`, and saturate at all-ones.
- Not defined: those ports and counters are absent. All other behaviour is identical.

## Structure
- Package `dg_pkg`:
  - record field LSB/width constants;
  - the record struct typedef `dg_rec_t` (da, prior, len, wait);
  - the FSM state enum;
  - the header-pack function.
- `dg_pkt_gen` instantiates no RAM. The bench pairs it with `dg_ram`.
- One sub-module is natural: `dg_beat_fmt` builds header/payload words from the record, `pkt_seq` and the beat index.

## Test plan
- RAM[0] = {wait=0, len=1, prior=2, da=5}, RAM[1] = 0, `i_rdy`=1, pulse start:
  - header 0x0000_00A5 with `o_sop`;
  - payload {ID, 0, 0} with `o_eop`;
  - then DONE.
- RAM[0] = {wait=3, len=4}, RAM[1] = {wait=0, len=2}, RAM[2] = 0:
  - SOP 4 cycles after LATCH;
  - EOP-to-SOP gap is 3 cycles;
  - second packet payload carries `pkt_seq`=1.
- Toggle `i_rdy` pseudo-randomly over a len=16 packet: data and flags are stable while stalled, and exactly 17 handshakes occur.
- All 2^ADDR_WIDTH records are nonzero with len=1: the run stops after address 1023 with no address wrap to 0, and `o_done`=1.
- Assert `rst` during DATA beat 5 of 10: next cycle `o_vld`=0, state IDLE, no `o_eop`. A new start replays from address 0.
- With `DG_STAT_EN`, run 3 packets of len 2, 3, 4: `o_pkt_cnt`=3 and `o_beat_cnt`=12. Pulse `i_start` while busy: no effect on the counters or the FSM.

Source files
------------

// File: rtl/dg_pkg.sv
// Shared record layout, FSM state type and header packing for the packet generator.
package dg_pkg;

  localparam int REC_DA_LSB    = 0;
  localparam int REC_DA_W      = 4;
  localparam int REC_PRIOR_LSB = 4;
  localparam int REC_PRIOR_W   = 3;
  localparam int REC_LEN_LSB   = 7;
  localparam int REC_LEN_W     = 10;
  localparam int REC_WAIT_LSB  = 17;
  localparam int REC_WAIT_W    = 10;

  // "wait" is a keyword, so the wait-count field is named wait_cyc
  typedef struct packed {
    logic [REC_WAIT_W-1:0]  wait_cyc;
    logic [REC_LEN_W-1:0]   len;
    logic [REC_PRIOR_W-1:0] prior;
    logic [REC_DA_W-1:0]    da;
  } dg_rec_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LATCH,
    ST_WAIT,
    ST_HDR,
    ST_DATA,
    ST_DONE
  } dg_state_t;

  function automatic dg_rec_t rec_unpack(input logic [31:0] word);
    dg_rec_t r;
    r.da       = word[REC_DA_LSB    +: REC_DA_W];
    r.prior    = word[REC_PRIOR_LSB +: REC_PRIOR_W];
    r.len      = word[REC_LEN_LSB   +: REC_LEN_W];
    r.wait_cyc = word[REC_WAIT_LSB  +: REC_WAIT_W];
    return r;
  endfunction

  function automatic logic [31:0] hdr_pack(input dg_rec_t r);
    return {15'b0, r.len, r.prior, r.da};
  endfunction

endpackage

// File: rtl/dg_beat_fmt.sv
// Beat word builder: header from the record, or payload {ID, pkt_seq, beat index}.
module dg_beat_fmt import dg_pkg::*; #(
  parameter int ID = 0
) (
  input  dg_rec_t     rec,
  input  logic [11:0] pkt_seq,
  input  logic [9:0]  beat_idx,
  input  logic        sel_hdr,
  output logic [31:0] word
);

  logic [3:0] port_id;

  assign port_id = 4'(ID);

  always_comb begin
    if (sel_hdr) word = hdr_pack(rec);
    else         word = {port_id, pkt_seq, 6'b0, beat_idx};
  end

endmodule

// File: rtl/dg_pkt_gen.sv
// Record-driven packet generator: walks the record RAM from address 0 and emits
// header + payload packets on valid/ready. Define DG_STAT_EN for packet/beat counters.
//
// state | meaning
// IDLE  | after reset, waiting for i_start
// FETCH | RAM read issued at o_ram_addr
// LATCH | record captured from i_ram_rdata; len==0 ends the run
// WAIT  | wait-count down-counter running, leaves at terminal count 0
// HDR   | header beat offered with o_sop
// DATA  | payload beats offered, o_eop on the last
// DONE  | run finished, waiting for i_start
module dg_pkt_gen import dg_pkg::*; #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int ID         = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  output logic                  o_ram_en,
  output logic                  o_ram_we,
  output logic [ADDR_WIDTH-1:0] o_ram_addr,
  output logic [DATA_WIDTH-1:0] o_ram_wdata,
  input  logic [DATA_WIDTH-1:0] i_ram_rdata,
  output logic                  o_vld,
  input  logic                  i_rdy,
  output logic                  o_sop,
  output logic                  o_eop,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_busy,
`ifdef DG_STAT_EN
  output logic [15:0]           o_pkt_cnt,
  output logic [31:0]           o_beat_cnt,
`endif
  output logic                  o_done
);

  dg_state_t state, state_nxt;
  dg_rec_t   rec, rec_rd;
  logic [9:0]  wait_cnt, beat_idx, beat_nxt;
  logic [11:0] pkt_seq;
  logic [31:0] fmt_word;
  logic hs, last_beat, eop_hs, start_ok, addr_last, sel_hdr;
  logic vld_d, sop_d, eop_d, ram_en_d, busy_d, done_d;
  logic [DATA_WIDTH-1:0] data_d;

  assign o_ram_we    = 1'b0;
  assign o_ram_wdata = '0;

  assign rec_rd    = rec_unpack(i_ram_rdata);
  assign hs        = o_vld & i_rdy;
  assign last_beat = (beat_idx == rec.len - 10'd1);
  assign eop_hs    = hs & (state == ST_DATA) & last_beat;
  assign start_ok  = i_start & ((state == ST_IDLE) | (state == ST_DONE));
  assign addr_last = &o_ram_addr;
  assign sel_hdr   = (state_nxt == ST_HDR);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE: if (i_start) state_nxt = ST_FETCH;
      ST_FETCH:         state_nxt = ST_LATCH;
      ST_LATCH:         state_nxt = (rec_rd.len == '0) ? ST_DONE : ST_WAIT;
      ST_WAIT:          if (wait_cnt == '0) state_nxt = ST_HDR;
      ST_HDR:           if (hs) state_nxt = ST_DATA;
      ST_DATA:          if (hs && last_beat) state_nxt = addr_last ? ST_DONE : ST_FETCH;
      default:          state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe
  always_comb begin
    beat_nxt = beat_idx;
    if (state == ST_HDR)            beat_nxt = '0;
    else if (state == ST_DATA && hs) beat_nxt = beat_idx + 10'd1;
    vld_d    = (state_nxt == ST_HDR) || (state_nxt == ST_DATA);
    sop_d    = (state_nxt == ST_HDR);
    eop_d    = (state_nxt == ST_DATA) && (beat_nxt == rec.len - 10'd1);
    ram_en_d = (state_nxt == ST_FETCH);
    busy_d   = !((state_nxt == ST_IDLE) || (state_nxt == ST_DONE));
    done_d   = (state_nxt == ST_DONE);
    data_d   = vld_d ? DATA_WIDTH'(fmt_word) : '0;
  end

  dg_beat_fmt #(.ID(ID)) u_fmt (
    .rec      (rec),
    .pkt_seq  (pkt_seq),
    .beat_idx (beat_nxt),
    .sel_hdr  (sel_hdr),
    .word     (fmt_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      o_vld    <= 1'b0;
      o_sop    <= 1'b0;
      o_eop    <= 1'b0;
      o_ram_en <= 1'b0;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
      o_data   <= '0;
    end else begin
      o_vld    <= vld_d;
      o_sop    <= sop_d;
      o_eop    <= eop_d;
      o_ram_en <= ram_en_d;
      o_busy   <= busy_d;
      o_done   <= done_d;
      o_data   <= data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rec        <= '0;
      wait_cnt   <= '0;
      beat_idx   <= '0;
      pkt_seq    <= '0;
      o_ram_addr <= '0;
    end else begin
      beat_idx <= beat_nxt;
      if (start_ok) begin
        o_ram_addr <= '0;
        pkt_seq    <= '0;
      end else if (eop_hs) begin
        pkt_seq <= pkt_seq + 12'd1;
        if (!addr_last) o_ram_addr <= o_ram_addr + ADDR_WIDTH'(1);
      end
      if (state == ST_LATCH) begin
        rec      <= rec_rd;
        wait_cnt <= rec_rd.wait_cyc;
      end else if (state == ST_WAIT && wait_cnt != '0) begin
        wait_cnt <= wait_cnt - 10'd1;
      end
    end
  end

`ifdef DG_STAT_EN
  always_ff @(posedge clk) begin
    if (rst || start_ok) begin
      o_pkt_cnt  <= '0;
      o_beat_cnt <= '0;
    end else begin
      if (hs && !(&o_beat_cnt))    o_beat_cnt <= o_beat_cnt + 32'd1;
      if (eop_hs && !(&o_pkt_cnt)) o_pkt_cnt  <= o_pkt_cnt + 16'd1;
    end
  end
`endif

endmodule
